// File: rtl/sync_word_packer.sv
// Packs LANES consecutive FIFO entries into one wide word with per-lane keep flags.
// Optional PACKER_TIMEOUT_EN flushes a partial word after TMO_CYCLES idle cycles.
module sync_word_packer #(
  parameter int DW         = 8,
  parameter int LANES      = 4,
  parameter int TMO_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         rdata,
  input  logic                  rrdy,
  output logic                  rget,
  input  logic                  flush,
  output logic [DW*LANES-1:0]   out_data,
  output logic [LANES-1:0]      out_keep,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CW = $clog2(LANES) + 1;

  if ((LANES < 2) || (TMO_CYCLES < 1)) begin : g_bad_cfg
    $error("sync_word_packer: LANES must be >= 2 and TMO_CYCLES >= 1");
  end

  typedef enum logic {FILL, HOLD} state_t;

  state_t                     state_q;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [LANES-1:0][DW-1:0]   data_q;
  logic [LANES-1:0]           keep_q;
  logic                       valid_q;
  logic                       cap, last, flush_req, go_hold;

  // Gating with rst keeps the FIFO from losing an entry on the reset edge.
  assign rget  = rrdy & (state_q == FILL) & ~rst;
  assign cap   = rget;
  assign cnt_d = cnt_q + {{(CW-1){1'b0}}, cap};
  assign last  = cap && (cnt_q == CW'(LANES-1));

`ifdef PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] idle_q;
  assign flush_req = flush | (idle_q == TW'(TMO_CYCLES));
`else
  assign flush_req = flush;
`endif

  // Flush counts an entry captured on the same edge, so a word is never empty.
  assign go_hold = (state_q == FILL) && (last || (flush_req && (cnt_d != '0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (cap) begin
            for (int i = 0; i < LANES; i++) begin
              if (cnt_q == CW'(i)) begin
                data_q[i] <= rdata;
                keep_q[i] <= 1'b1;
              end
            end
            cnt_q <= cnt_d;
          end
          if (go_hold) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

`ifdef PACKER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || cap || go_hold || (state_q != FILL)) idle_q <= '0;
    else if (cnt_q != '0)                           idle_q <= idle_q + TW'(1);
  end
`endif

  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_sync_word_packer.sv
// Directed per-cycle vector table for sync_word_packer plus timeout corner sequence.
module tb_sync_word_packer;

  logic        clk = 1'b0;
  logic        rst, rrdy, flush, out_ready;
  logic [7:0]  rdata;
  logic        rget, out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  int checks = 0;
  int errors = 0;

  sync_word_packer #(.DW(8), .LANES(4), .TMO_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rdata(rdata), .rrdy(rrdy), .rget(rget), .flush(flush),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rrdy;
    logic [7:0]  rdata;
    logic        flush, ordy;
    logic        e_rget, e_valid;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
  } vec_t;

  vec_t tv[$];

  function automatic void v(logic r, logic rr, logic [7:0] d, logic f, logic o,
                            logic eg, logic ev, logic [31:0] ed, logic [3:0] ek);
    vec_t t;
    t.rst = r; t.rrdy = rr; t.rdata = d; t.flush = f; t.ordy = o;
    t.e_rget = eg; t.e_valid = ev; t.e_data = ed; t.e_keep = ek;
    tv.push_back(t);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    int n;
    logic seen;
    rst = 1'b1; rrdy = 1'b0; rdata = '0; flush = 1'b0; out_ready = 1'b0;

    // reset with rrdy high: no pop, everything cleared
    v(1,1,8'h00,0,0, 0,0,32'h0,4'h0);
    v(0,0,8'h00,0,0, 0,0,32'h0,4'h0);
    // full word, accepted immediately, then one-cycle bubble
    v(0,1,8'h11,0,1, 1,0,32'h00000011,4'h1);
    v(0,1,8'h22,0,1, 1,0,32'h00002211,4'h3);
    v(0,1,8'h33,0,1, 1,0,32'h00332211,4'h7);
    v(0,1,8'h44,0,1, 1,1,32'h44332211,4'hF);
    v(0,1,8'h55,0,1, 0,0,32'h0,4'h0);
    v(0,1,8'h55,0,1, 1,0,32'h00000055,4'h1);
    v(0,1,8'h66,0,0, 1,0,32'h00006655,4'h3);
    v(0,1,8'h77,0,0, 1,0,32'h00776655,4'h7);
    v(0,1,8'h88,0,0, 1,1,32'h88776655,4'hF);
    // held word with backpressure; a flush in HOLD is ignored
    for (int i = 0; i < 5; i++) v(0,1,8'h99,(i == 2),0, 0,1,32'h88776655,4'hF);
    v(0,1,8'h99,0,1, 0,0,32'h0,4'h0);
    v(0,1,8'h55,0,0, 1,0,32'h00000055,4'h1);
    v(0,0,8'h00,1,0, 0,1,32'h00000055,4'h1);
    v(0,0,8'h00,0,1, 0,0,32'h0,4'h0);
    // partial word flush, then flush with nothing buffered
    v(0,1,8'hAA,0,0, 1,0,32'h000000AA,4'h1);
    v(0,1,8'hBB,0,0, 1,0,32'h0000BBAA,4'h3);
    v(0,0,8'h00,0,0, 0,0,32'h0000BBAA,4'h3);
    v(0,0,8'h00,1,0, 0,1,32'h0000BBAA,4'h3);
    v(0,0,8'h00,0,1, 0,0,32'h0,4'h0);
    v(0,0,8'h00,1,0, 0,0,32'h0,4'h0);
    v(0,0,8'h00,0,1, 0,0,32'h0,4'h0);
    // flush coincident with the last lane: one full word only
    v(0,1,8'h01,0,0, 1,0,32'h00000001,4'h1);
    v(0,1,8'h02,0,0, 1,0,32'h00000201,4'h3);
    v(0,1,8'h03,0,0, 1,0,32'h00030201,4'h7);
    v(0,1,8'h04,1,0, 1,1,32'h04030201,4'hF);
    v(0,0,8'h00,0,1, 0,0,32'h0,4'h0);
    v(0,0,8'h00,0,1, 0,0,32'h0,4'h0);
    // flush with a same-edge capture at cnt=0, then reset discards held word
    v(0,1,8'h5A,1,0, 1,1,32'h0000005A,4'h1);
    v(0,1,8'h5B,0,0, 0,1,32'h0000005A,4'h1);
    v(1,1,8'h5B,0,0, 0,0,32'h0,4'h0);
    v(0,0,8'h00,0,1, 0,0,32'h0,4'h0);
    // reset mid-fill restarts at lane 0
    v(0,1,8'h12,0,0, 1,0,32'h00000012,4'h1);
    v(1,1,8'h13,0,0, 0,0,32'h0,4'h0);
    v(0,1,8'h34,0,0, 1,0,32'h00000034,4'h1);
    v(0,0,8'h00,1,0, 0,1,32'h00000034,4'h1);
    v(0,0,8'h00,0,1, 0,0,32'h0,4'h0);

    foreach (tv[k]) begin
      @(negedge clk);
      rst = tv[k].rst; rrdy = tv[k].rrdy; rdata = tv[k].rdata;
      flush = tv[k].flush; out_ready = tv[k].ordy;
      #1 chk($sformatf("v%0d.rget", k), {31'b0, rget}, {31'b0, tv[k].e_rget});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.valid", k), {31'b0, out_valid}, {31'b0, tv[k].e_valid});
      chk($sformatf("v%0d.data", k), out_data, tv[k].e_data);
      chk($sformatf("v%0d.keep", k), {28'b0, out_keep}, {28'b0, tv[k].e_keep});
    end

    // single entry then idle: timed flush or held until external flush
    @(negedge clk);
    rst = 1'b0; rrdy = 1'b1; rdata = 8'h7E; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rrdy = 1'b0;
`ifdef PACKER_TIMEOUT_EN
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      seen = out_valid;
    end
    chk("tmo.seen", {31'b0, seen}, 32'd1);
    chk("tmo.latency", n, 17);
`else
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 seen = seen | out_valid;
    end
    chk("notmo.held", {31'b0, seen}, 32'd0);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 chk("notmo.valid", {31'b0, out_valid}, 32'd1);
    flush = 1'b0;
`endif
    chk("tail.data", out_data, 32'h0000007E);
    chk("tail.keep", {28'b0, out_keep}, 32'h1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("tail.accept", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_word_packer.md
Name: sync_word_packer

Overview:
Read-domain consumer placed directly downstream of the cdc_syncfifo read port. It pops DW-bit entries using the rrdy/rget handshake and packs LANES consecutive entries into one wide word. Each word is presented on a valid/ready output interface. A flush request emits a partially filled word with byte-lane keep flags.

Parameters:
DW, 8, width of one FIFO entry (one lane)
LANES, 4, entries packed per output word (>=2)
TMO_CYCLES, 16, idle cycles before automatic flush (used only with the optional feature)

Ports:
clk  input  1  read-domain clock (same clock as the FIFO rclk)
rst  input  1  synchronous, active-high reset
rdata  input  DW  FIFO read data, valid while rrdy=1
rrdy  input  1  FIFO has an entry available
rget  output  1  pop strobe to FIFO; entry consumed on the clk edge where rget=1
flush  input  1  request to emit the current partial word
out_data  output  DW*LANES  packed word; lane 0 is at the LSBs
out_keep  output  LANES  per-lane valid flags for out_data
out_valid  output  1  output word valid
out_ready  input  1  downstream accept

Behaviour:
- One clock; reset is synchronous and active-high. All state is sampled on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_keep=0, state=FILL, lane count cnt=0, idle counter=0.
- rget is combinational: rget = rrdy & (state==FILL). It is never asserted in HOLD or during rst.
- FILL state:
  - On an edge with rget=1, rdata is written into lane cnt, out_keep[cnt] is set, and cnt increments.
  - Entries fill lanes in arrival order: first entry goes to lane 0.
  - If the captured entry lands in lane LANES-1, go to HOLD; out_valid=1 on the next cycle.
  - Latency: one cycle from the capture edge of the last entry to out_valid.
- Flush:
  - flush=1 in FILL with cnt>0 (counting any entry captured on the same edge) -> go to HOLD.
  - out_keep marks only the filled lanes; unfilled lanes of out_data read 0.
  - flush on the same edge as the capture into lane LANES-1 -> exactly one full word (keep all ones), no extra word.
  - flush with cnt=0 and no capture -> ignored.
  - flush in HOLD -> ignored; it is not remembered.
- HOLD state:
  - out_valid=1; out_data and out_keep are stable until accepted.
  - On an edge with out_ready=1: out_valid=0, out_data=0, out_keep=0, cnt=0, go to FILL.
  - No pass-through in the accept cycle: rget stays 0, giving a one-cycle bubble. Peak throughput is LANES+1 cycles per word.
- out_ready while out_valid=0 has no effect.
- rrdy dropping mid-word leaves the partial word held in FILL indefinitely; no entry is lost.
- rst asserted in any state returns everything to reset values on that edge.
  - A held word or partial word is discarded.
  - No rget is issued during the reset cycle.
- cnt width is clog2(LANES)+1; it never exceeds LANES.

Optional Feature:
Macro: PACKER_TIMEOUT_EN
- Defined:
  - An idle counter increments each cycle in FILL while cnt>0 and rget=0.
  - It clears on any capture, on entering HOLD, and on reset.
  - When it reaches TMO_CYCLES, an internal flush is generated with the same behaviour as flush=1.
  - Saturation is not needed, because the flush clears the counter.
- Not defined:
  - No idle counter is built; TMO_CYCLES is unused.
  - Partial words leave only on an external flush.

Test Plan:
- Reset, then idle -> out_valid=0, out_keep=0, out_data=0, rget=0 while rrdy=0.
- rrdy=1 supplying 0x11,0x22,0x33,0x44, out_ready=1 -> one word with out_data=0x44332211, out_keep=0xF, out_valid for 1 cycle; next word's first rget one cycle after accept.
- Full word held with out_ready=0 for 5 cycles and rrdy=1 -> out_data stays constant, rget=0 throughout; after out_ready=1 the next entry 0x55 lands in lane 0.
- Entries 0xAA,0xBB then rrdy=0 and a 1-cycle flush -> out_data=0x0000BBAA, out_keep=0x3. A second flush with cnt=0 produces no word.
- flush on the same edge as the 4th entry 0x04 (after 0x01,0x02,0x03) -> exactly one word 0x04030201 with keep 0xF.
- rst asserted during HOLD -> out_valid=0 next cycle and the word is discarded. With PACKER_TIMEOUT_EN and TMO_CYCLES=16: one entry 0x7E then idle -> word 0x0000007E, keep 0x1, out_valid asserted 17 cycles after capture.
